// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: widths, JAL opcode, FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ifetch_queue_pkg;

  localparam int INS_W  = 32;
  localparam int ADDR_W = 32;

  localparam logic [6:0] JAL_OP = 7'b1101111;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_t;

  // One queued instruction: word plus the address it was fetched from.
  typedef struct packed {
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] pc;
  } ifq_entry_t;

  // J-type immediate, sign-extended to 32 bits.
  function automatic logic [ADDR_W-1:0] jal_imm(input logic [INS_W-1:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular FIFO holding fetched {ins, pc} entries; clr empties it in one edge.
// Latency: push visible at head/count one edge later; head is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; clr wins over both.
// Ports: clk/rst_n, push+push_data, pop, clr, full, empty, count, head.
module ifq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetches instruction words from memory, queues {ins, pc}, issues one per cycle to the decoder.
// Latency: first ins_flg two edges after mem_ack; one outstanding memory request at a time.
// Backpressure: stall_in holds the queue; no request is issued while the queue is full.
// Ports: clk_in/rst_n; stall_in, jump_flg/jump_pc from downstream; mem_req/mem_addr/mem_ack/mem_data
// to memory; ins_flg/ins/pc to the decoder.
// Build option: IFQ_JAL_PREDICT_EN makes a fetched JAL steer the next fetch to its target.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        jump_flg,
  input  logic [31:0] jump_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        ins_flg,
  output logic [31:0] ins,
  output logic [31:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  ifq_state_t      state;
  logic [31:0]     fetch_pc;
  logic [31:0]     next_pc;
  logic            can_req;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
  ifq_entry_t      push_entry;
  ifq_entry_t      head;

  // Only one request is ever in flight, so count < DEPTH guarantees room for its response.
  assign can_req = (count < FULL_CNT);
  assign push    = (state == IFQ_WAIT) && mem_ack && !jump_flg && !full;
  assign pop     = !empty && !stall_in && !jump_flg;

  assign push_entry.ins = mem_data;
  assign push_entry.pc  = mem_addr;

`ifdef IFQ_JAL_PREDICT_EN
  assign next_pc = (mem_data[6:0] == JAL_OP) ? (mem_addr + jal_imm(mem_data))
                                             : (fetch_pc + 32'd4);
`else
  assign next_pc = fetch_pc + 32'd4;
`endif

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifq_entry_t))
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clr       (jump_flg),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  // Fetch FSM. A redirect while a request is in flight still has to wait out that
  // response (DROP) because the memory side cannot cancel it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IFQ_IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      unique case (state)
        IFQ_IDLE: begin
          if (jump_flg) begin
            fetch_pc <= jump_pc;
          end else if (can_req) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= IFQ_WAIT;
          end
        end
        IFQ_WAIT: begin
          if (jump_flg) begin
            fetch_pc <= jump_pc;
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IFQ_IDLE;
            end else begin
              state   <= IFQ_DROP;
            end
          end else if (mem_ack) begin
            fetch_pc <= next_pc;
            mem_req  <= 1'b0;
            state    <= IFQ_IDLE;
          end
        end
        IFQ_DROP: begin
          if (jump_flg) begin
            fetch_pc <= jump_pc;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IFQ_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IFQ_IDLE;
        end
      endcase
    end
  end

  // Registered issue port; ins/pc keep their last value when nothing is issued.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ins_flg <= 1'b0;
      ins     <= '0;
      pc      <= '0;
    end else begin
      ins_flg <= pop;
      if (pop) begin
        ins <= head.ins;
        pc  <= head.pc;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios, scoreboard-checked issue stream.
// Latency: n/a.
// Backpressure: memory model acks after a programmable number of cycles, up to an ack budget.
module tb_ifetch_queue;

  logic        clk_in   = 1'b0;
  logic        rst_n    = 1'b0;
  logic        stall_in = 1'b0;
  logic        jump_flg = 1'b0;
  logic [31:0] jump_pc  = 32'h0;
  logic        mem_ack  = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        ins_flg;
  logic [31:0] ins;
  logic [31:0] pc;

  ifetch_queue #(.DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .stall_in (stall_in),
    .jump_flg (jump_flg),
    .jump_pc  (jump_pc),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .ins_flg  (ins_flg),
    .ins      (ins),
    .pc       (pc)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  exp_t        mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model knobs
  int budget = 0;
  int lat    = 0;
  int acks   = 0;
  int mcnt   = 0;
  bit poison = 1'b0;
  bit jal_mode = 1'b0;
  int first_ack_cyc = -1;
  int first_flg_cyc = -1;
  int bad_seen = 0;
  bit prev_req = 1'b0;
  int run;
  logic [31:0] exp_jal_next;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic push_exp(input logic [31:0] w, input logic [31:0] a);
    exp_t e;
    e.ins = w;
    e.pc  = a;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (addr_log.size() > i) return addr_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Memory: acks once mem_req has been high for lat+1 sampled cycles, while budget lasts.
  always @(negedge clk_in) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end else if (mem_req && budget > 0) begin
      mcnt++;
      if (mcnt > lat) begin
        mem_ack = 1'b1;
        if (poison)                           mem_data = 32'hDEAD_BEEF;
        else if (jal_mode && mem_addr == 32'd8) mem_data = 32'h0100_006F;
        else                                  mem_data = 32'h0000_0013 + mem_addr;
        poison = 1'b0;
        budget--;
        acks++;
        mcnt = 0;
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end
  end

  // Monitor: logs new requests and checks every issued instruction against the scoreboard.
  always @(negedge clk_in) begin
    if (rst_n) begin
      if (mem_req && !prev_req) addr_log.push_back(mem_addr);
      prev_req = mem_req;
      if (ins_flg) begin
        if (first_flg_cyc < 0) first_flg_cyc = cyc;
        if (ins == 32'hDEAD_BEEF) bad_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got pc=0x%08h ins=0x%08h, expected no instruction", pc, ins);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("sb_pc", pc, mon_e.pc);
          check_eq("sb_ins", ins, mon_e.ins);
        end
      end
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    stall_in = 1'b0;
    jump_flg = 1'b0;
    jump_pc  = 32'h0;
    budget   = 0;
    lat      = 0;
    poison   = 1'b0;
    jal_mode = 1'b0;
    acks     = 0;
    exp_q.delete();
    addr_log.delete();
    repeat (2) @(negedge clk_in);
    first_ack_cyc = -1;
    first_flg_cyc = -1;
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 300 && addr_log.size() < n; i++) @(negedge clk_in);
    if (addr_log.size() < n) begin
      n_checks++;
      $display("FAIL req_timeout: got %0d requests, expected %0d", addr_log.size(), n);
    end
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 300 && acks < n; i++) @(negedge clk_in);
    if (acks < n) begin
      n_checks++;
      $display("FAIL ack_timeout: got %0d acks, expected %0d", acks, n);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk_in);
    check_eq(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    // ---- reset values ----
    @(negedge clk_in);
    check_eq("rst_ins_flg", {31'b0, ins_flg}, 32'd0);
    check_eq("rst_ins", ins, 32'd0);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);

    // ---- sequential fetch, 1-cycle memory ----
    do_reset();
    push_exp(32'h13, 32'd0);
    push_exp(32'h17, 32'd4);
    push_exp(32'h1B, 32'd8);
    budget = 3;
    wait_log(3);
    check_eq("seq_addr0", log_at(0), 32'd0);
    check_eq("seq_addr1", log_at(1), 32'd4);
    check_eq("seq_addr2", log_at(2), 32'd8);
    drain("seq_drain");
    check_eq("first_latency", first_flg_cyc - first_ack_cyc, 32'd2);

    // ---- stall fills queue to DEPTH, then release ----
    do_reset();
    stall_in = 1'b1;
    for (int i = 0; i < 16; i++) push_exp(32'h13 + 4 * i, 4 * i);
    budget = 16;
    repeat (40) @(negedge clk_in);
    check_eq("full_acks", acks, 32'd16);
    run = 0;
    repeat (5) begin
      @(negedge clk_in);
      if (mem_req) run++;
    end
    check_eq("full_no_req", run, 32'd0);
    stall_in = 1'b0;
    run = 0;
    repeat (16) begin
      @(negedge clk_in);
      if (ins_flg) run++;
    end
    check_eq("full_burst", run, 32'd16);
    @(negedge clk_in);
    check_eq("full_burst_end", {31'b0, ins_flg}, 32'd0);
    drain("full_drain");

    // ---- redirect while waiting, late ack is dropped ----
    do_reset();
    stall_in = 1'b1;
    budget = 2;
    wait_acks(2);
    wait_log(3);
    @(posedge clk_in);
    budget = 1;
    lat    = 3;
    poison = 1'b1;
    @(negedge clk_in);
    jump_flg = 1'b1;
    jump_pc  = 32'h1000;
    stall_in = 1'b0;
    @(negedge clk_in);
    jump_flg = 1'b0;
    check_eq("drop_no_flg", {31'b0, ins_flg}, 32'd0);
    check_eq("drop_req_held", {31'b0, mem_req}, 32'd1);
    @(negedge clk_in);
    check_eq("drop_queue_empty", {31'b0, ins_flg}, 32'd0);
    wait_log(4);
    check_eq("drop_next_addr", log_at(3), 32'h1000);
    @(posedge clk_in);
    push_exp(32'h1013, 32'h1000);
    lat    = 0;
    budget = 1;
    drain("drop_drain");
    check_eq("drop_never_issued", bad_seen, 32'd0);

    // ---- redirect in the same cycle as ack ----
    do_reset();
    budget = 1;
    lat    = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      #1;
      if (mem_ack) break;
    end
    jump_flg = 1'b1;
    jump_pc  = 32'h2000;
    @(negedge clk_in);
    jump_flg = 1'b0;
    check_eq("sameack_no_flg", {31'b0, ins_flg}, 32'd0);
    check_eq("sameack_req_low", {31'b0, mem_req}, 32'd0);
    @(negedge clk_in);
    check_eq("sameack_no_flg2", {31'b0, ins_flg}, 32'd0);
    wait_log(2);
    check_eq("sameack_next_addr", log_at(1), 32'h2000);
    @(posedge clk_in);
    push_exp(32'h2013, 32'h2000);
    lat    = 0;
    budget = 1;
    drain("sameack_drain");

    // ---- asynchronous reset with a non-empty queue ----
    do_reset();
    push_exp(32'h13, 32'd0);
    push_exp(32'h17, 32'd4);
    push_exp(32'h1B, 32'd8);
    budget = 3;
    drain("midrst_pre_drain");
    stall_in = 1'b1;
    @(posedge clk_in);
    budget = 2;
    wait_acks(5);
    repeat (2) @(negedge clk_in);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ins_flg", {31'b0, ins_flg}, 32'd0);
    check_eq("midrst_ins", ins, 32'd0);
    check_eq("midrst_pc", pc, 32'd0);
    check_eq("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("midrst_mem_addr", mem_addr, 32'h0);
    exp_q.delete();
    addr_log.delete();
    stall_in = 1'b0;
    budget   = 0;
    @(negedge clk_in);
    rst_n = 1'b1;
    wait_log(1);
    check_eq("midrst_first_addr", log_at(0), 32'h0);
    repeat (10) @(negedge clk_in);
    drain("midrst_post_empty");

    // ---- JAL at pc 8 ----
`ifdef IFQ_JAL_PREDICT_EN
    exp_jal_next = 32'd24;
`else
    exp_jal_next = 32'd12;
`endif
    do_reset();
    jal_mode = 1'b1;
    push_exp(32'h13, 32'd0);
    push_exp(32'h17, 32'd4);
    push_exp(32'h0100_006F, 32'd8);
    push_exp(32'h13 + exp_jal_next, exp_jal_next);
    budget = 4;
    wait_log(4);
    check_eq("jal_next_addr", log_at(3), exp_jal_next);
    drain("jal_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
